// File: rtl/operand_accumulator.sv
// operand_accumulator: folds a frame of N_OPERANDS bytes into an 8-bit sum with sticky carry; OPERAND_ACCUMULATOR_SATURATE_EN clamps to 8'hFF on carry
module operand_accumulator #(
  parameter int N_OPERANDS = 8,
  localparam int CNT_W = $clog2(N_OPERANDS + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_data,
  output logic             busy,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [7:0]       out_sum,
  output logic             out_carry,
  output logic [CNT_W-1:0] out_count
);
  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;
  state_t state, state_nx;
  logic [7:0] acc, acc_nx;
  logic flag;
  logic [CNT_W-1:0] count;
  logic [8:0] sum;
  logic beat, last;
  assign beat = in_valid & in_ready;
  assign sum = {1'b0, acc} + {1'b0, in_data};
  assign last = count == CNT_W'(N_OPERANDS - 1);
`ifdef OPERAND_ACCUMULATOR_SATURATE_EN
  assign acc_nx = sum[8] ? 8'hFF : sum[7:0];
`else
  assign acc_nx = sum[7:0];
`endif
  assign out_sum = acc;
  assign out_carry = flag;
  assign out_count = count;
  // state register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  // next state and handshake outputs
  always_comb begin
    state_nx = state;
    in_ready = state == ACCUM;
    out_valid = state == DONE;
    busy = state != IDLE;
    if (state == IDLE && start) state_nx = ACCUM;
    if (state == ACCUM && beat && last) state_nx = DONE;
    if (state == DONE && out_ready) state_nx = IDLE;
  end
  // running sum, sticky carry and beat count; cleared when a frame starts
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      acc <= '0;
      flag <= 1'b0;
      count <= '0;
    end else if (state == IDLE && start) begin
      acc <= '0;
      flag <= 1'b0;
      count <= '0;
    end else if (beat) begin
      acc <= acc_nx;
      flag <= flag | sum[8];
      count <= count + 1'b1;
    end
endmodule

// File: doc/operand_accumulator.md
Name: operand_accumulator

Overview:
Sequential front-end that feeds the team's 8-bit ripple-carry adder stage. It accepts a frame of N_OPERANDS 8-bit operands over a valid/ready stream and folds each operand into a running 8-bit sum through one adder evaluation per accepted beat. It then presents the final sum plus a sticky carry-out flag on an output valid/ready port. In the game-of-life datapath it totals neighbour counts and weights before the rule-evaluation stage.

Parameters:
N_OPERANDS, 8, operands per frame; legal range 1..255.
CNT_W, $clog2(N_OPERANDS+1), width of the operand counter and out_count; derived, not overridden.

Ports:
clk  input  1  system clock, rising edge.
rst_n  input  1  asynchronous active-low reset.
start  input  1  one-cycle request to begin a frame; honoured only in IDLE.
in_valid  input  1  operand present on in_data.
in_ready  output  1  block will accept in_data this cycle.
in_data  input  8  operand, unsigned.
busy  output  1  high in ACCUM and DONE.
out_valid  output  1  result held on out_sum/out_carry/out_count.
out_ready  input  1  consumer takes result.
out_sum  output  8  accumulated sum mod 256.
out_carry  output  1  sticky: any addition in the frame produced carry-out of bit 7.
out_count  output  CNT_W  operands accepted in the frame; equals N_OPERANDS at DONE.

Behaviour:
- Reset (async, rst_n=0): state=IDLE; acc=0, carry flag=0, count=0. in_ready=0, busy=0, out_valid=0, out_sum=0, out_carry=0, out_count=0.
- Outputs out_sum/out_carry/out_count are registered copies of acc/flag/count.
- IDLE: in_ready=0. start=1 -> ACCUM next cycle; acc, flag and count are cleared on that edge.
- ACCUM: in_ready=1. Beat = in_valid&in_ready. On a beat: acc <= acc+in_data mod 256; flag <= flag | carry-out(acc+in_data); count <= count+1. When the beat brings count to N_OPERANDS -> DONE.
- Cycles with in_valid=0 in ACCUM hold all state. No limit on the gap between beats.
- Latency: out_valid rises on the first cycle after the final beat. Minimum frame time is N_OPERANDS+2 cycles from start to out_valid.
- DONE: in_ready=0, out_valid=1, and outputs are held stable until out_ready=1. On out_valid&out_ready the block returns to IDLE on that edge. out_valid drops next cycle; out_sum/out_carry/out_count keep their values until the next start.
- start is ignored in ACCUM and DONE and has no effect on the frame in progress.
- start and out_ready both high in DONE: handshake completes and the block goes to IDLE. That start is ignored; a new start is needed in IDLE.
- in_valid during IDLE or DONE: not accepted, no state change.
- N_OPERANDS=1: a single beat goes straight to DONE.
- Carry flag is sticky: a wrap on any beat sets it, and later beats never clear it.
- rst_n asserted mid-frame: immediate return to reset values; the partial sum is discarded.

Optional Feature:
Macro OPERAND_ACCUMULATOR_SATURATE_EN.
- Defined: on a beat whose addition carries out, acc <= 8'hFF instead of the wrapped value. Once acc=8'hFF it stays there for the rest of the frame. out_carry behaves as defined above and so marks a saturated result.
- Undefined: modulo-256 wrap as specified. No saturation logic is present.

Test Plan:
- Reset mid-frame: start, 3 beats of 8'h10, assert rst_n=0 -> all outputs 0 immediately. Return to IDLE; in_ready=0.
- Basic frame, N_OPERANDS=8: start, operands 1..8 back-to-back -> out_valid on the cycle after the 8th beat. out_sum=36, out_carry=0, out_count=8, min latency 10 cycles from start.
- Wrap: operands 8'hF0, 8'h20, then six 8'h00 -> out_sum=8'h10, out_carry=1. With SATURATE_EN: out_sum=8'hFF, out_carry=1.
- Stalls and backpressure: random in_valid gaps, out_ready held low 5 cycles -> sum unchanged by gaps. out_valid and outputs stable all 5 cycles; IDLE one cycle after out_ready=1.
- Ignored start: pulse start during ACCUM beat 4 and during DONE -> frame result unaffected, no restart. Block remains IDLE after the handshake until the next start.
- N_OPERANDS=1: start, single beat 8'hAB -> out_sum=8'hAB, out_count=1, out_valid the next cycle.
